// File: rtl/fsm_alu_seq.sv
// Four-state Moore sequencer (S0->S1->S2->S3) with a per-state ALU and registered result, flags and wrap counter.
// Optional macro FSM_ALU_SAT_EN: saturate the S1 subtract at zero and the S2 add at all-ones.
module fsm_alu_seq #(
    parameter int WIDTH  = 4,
    parameter int OFFSET = 4,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             input_bit,
    input  logic [WIDTH-1:0] RA,
    input  logic [WIDTH-1:0] RB,
    output logic [WIDTH-1:0] RA_out,
    output logic [WIDTH-1:0] RC,
    output logic             rc_valid,
    output logic             flag,
    output logic             output_bit,
    output logic [1:0]       present_state,
    output logic [1:0]       next_state,
    output logic [CNT_W-1:0] wrap_count
);

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } state_t;

    localparam logic [WIDTH-1:0] OFF_W = WIDTH'(OFFSET);

    state_t           state_q, state_d;
    logic [WIDTH:0]   diff, sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_flag;

    always_comb begin
        state_d = state_q;
        if (in_valid && !input_bit) begin
            case (state_q)
                S0:      state_d = S1;
                S1:      state_d = S2;
                S2:      state_d = S3;
                default: state_d = S0;
            endcase
        end
    end

    // Both wide results are always formed; bit WIDTH is the borrow/carry.
    always_comb begin
        diff     = {1'b0, RA} - {1'b0, RB};
        sum      = {1'b0, ~RA} + {1'b0, OFF_W};
        alu_res  = '0;
        alu_flag = 1'b0;
        case (state_q)
            S0: begin
                alu_res  = RA | RB;
                alu_flag = (alu_res == '0);
            end
            S1: begin
                alu_flag = diff[WIDTH];
`ifdef FSM_ALU_SAT_EN
                alu_res  = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
`else
                alu_res  = diff[WIDTH-1:0];
`endif
            end
            S2: begin
                alu_flag = sum[WIDTH];
`ifdef FSM_ALU_SAT_EN
                alu_res  = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
`else
                alu_res  = sum[WIDTH-1:0];
`endif
            end
            default: begin
                alu_res  = RA ^ RB;
                alu_flag = (alu_res == '0);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S0;
            RA_out     <= '0;
            RC         <= '0;
            flag       <= 1'b0;
            rc_valid   <= 1'b0;
            wrap_count <= '0;
        end else begin
            state_q  <= state_d;
            rc_valid <= in_valid;
            if (in_valid) begin
                RA_out <= ~RA;
                RC     <= alu_res;
                flag   <= alu_flag;
            end
            if (state_q == S3 && state_d == S0)
                wrap_count <= wrap_count + CNT_W'(1);
        end
    end

    assign present_state = state_q;
    assign next_state    = state_d;
    assign output_bit    = (state_q == S1);

endmodule

// File: doc/fsm_alu_seq.md
Name: fsm_alu_seq

Overview:
- Parametrised successor to the team's 4-state sequence-detector/ALU block.
- A Moore FSM steps S0→S1→S2→S3→S0 under control of a serial input bit. Each state selects an ALU operation on two WIDTH-bit operands.
- Result, flags and complement output are registered, with a valid strobe and a wrap counter.
- Sits beside the lab datapath as the per-state operation sequencer.

Parameters:
- WIDTH, 4, operand/result width in bits (≥2)
- OFFSET, 4, constant added to ~RA in state S2 (truncated to WIDTH)
- CNT_W, 8, width of wrap counter

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk)
- in_valid  input  1  qualifies input_bit, RA, RB this cycle
- input_bit  input  1  serial control bit; 0 = advance, 1 = hold
- RA  input  WIDTH  operand A
- RB  input  WIDTH  operand B
- RA_out  output  WIDTH  registered ~RA
- RC  output  WIDTH  registered ALU result
- rc_valid  output  1  one-cycle strobe: RC/flag updated
- flag  output  1  carry/borrow/zero flag per state (see below)
- output_bit  output  1  Moore output, 1 iff present_state==S1
- present_state  output  2  current state, S0=2'b00 … S3=2'b11
- next_state  output  2  combinational next state
- wrap_count  output  CNT_W  number of completed S3→S0 transitions

Behaviour:
- Reset (reset==0 at posedge): present_state=S0, RA_out=0, RC=0, flag=0, rc_valid=0, wrap_count=0. Reset overrides in_valid. A mid-sequence reset returns to S0 on the same edge, and no rc_valid is issued for that cycle.
- next_state (combinational):
  - in_valid==0 or input_bit==1 → present_state.
  - Otherwise S0→S1, S1→S2, S2→S3, S3→S0.
- present_state <= next_state every non-reset edge.
- output_bit = (present_state==S1), purely combinational from present_state. No dependence on inputs.
- ALU, evaluated on present_state and captured on the posedge when in_valid==1, with rc_valid=1 the following cycle (latency 1). When in_valid==0: RC/flag hold, rc_valid=0.
  - S0: RC = RA | RB (bitwise); flag = (RC==0).
  - S1: RC = RA − RB mod 2^WIDTH; flag = borrow (RA<RB, unsigned).
  - S2: RC = (~RA + OFFSET) mod 2^WIDTH; flag = carry-out of the WIDTH+1-bit sum.
  - S3: RC = RA ^ RB; flag = (RC==0).
- RA_out <= ~RA on every in_valid cycle, otherwise held.
- wrap_count:
  - Increments on each edge where present_state==S3 and next_state==S0.
  - Wraps modulo 2^CNT_W (all-ones → 0) with no flag.
- in_valid==1 with input_bit==1 on consecutive cycles: state holds, and RC recomputes every cycle with rc_valid held high.

Optional Feature:
- Macro FSM_ALU_SAT_EN.
- Defined:
  - S1 saturates at 0 on borrow (RC=0, flag=1).
  - S2 saturates at all-ones on carry (RC={WIDTH{1'b1}}, flag=1).
  - Flags keep the same meaning.
- Undefined: modular wrap as above. No other behaviour changes.

Test Plan:
- Reset/hold: hold reset=0 for 3 cycles, release, with in_valid=0 → present_state=0, RC=0, rc_valid=0, wrap_count=0 throughout.
- Full walk, WIDTH=4: RA=4'h6, RB=4'h3, in_valid=1, input_bit=0 for 4 cycles →
  - States 0,1,2,3,0.
  - RC sequence 7, 3, 5 (~6=9, +4=13? no: ~6=4'h9, +4=4'hD) → check 4'h7, 4'h3, 4'hD, 4'h5, each one cycle after the state.
  - output_bit=1 only in S1.
  - wrap_count=1.
- Borrow: in S1 with RA=2, RB=5 → RC=4'hD, flag=1. With FSM_ALU_SAT_EN → RC=0, flag=1.
- Carry: in S2 with RA=1, OFFSET=4 → ~1=4'hE, +4 → RC=4'h2, flag=1. With FSM_ALU_SAT_EN → RC=4'hF.
- Hold/qualify: input_bit=1 for 5 cycles in S2 → state stays 2, and rc_valid stays high. Then in_valid=0 with input_bit=0 → state unchanged, rc_valid=0, RC held.
- Reset mid-operation and counter wrap:
  - CNT_W=2: run 5 full loops → wrap_count=1.
  - Assert reset in S2 → next edge S0, RC=0, wrap_count=0.
